// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared types and constants
// for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    ERR
  } state_t;

  localparam int MUL_STEPS    = 33;
  localparam int DEF_WD_LIMIT = 40;
  localparam int DEF_TAG_W    = 4;

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with
// a one-bit priority pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // favour the pointed requester, fall back to the other
  always_comb begin
    grant[0] = valid[0] & (~ptr | ~valid[1]);
    grant[1] = valid[1] & (ptr | ~valid[0]);
  end

  // after an accept, priority passes to the one not served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end sharing one
// iterative 32x32 multiplier between two requesters.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int TAG_W    = DEF_TAG_W,
  parameter int WD_LIMIT = DEF_WD_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x,
  input  logic [31:0]      req0_y,
  input  logic             req0_unsigned,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x,
  input  logic [31:0]      req1_y,
  input  logic             req1_unsigned,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [63:0]      rsp0_z,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [63:0]      rsp1_z,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             mul_run,
  output logic             mul_op_unsigned,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  input  logic             mul_stall,
  input  logic [63:0]      mul_z,
  output logic             busy,
  output logic             wd_err
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(WD_LIMIT - 1);

  state_t           state;
  logic [31:0]      op_x;
  logic [31:0]      op_y;
  logic             op_uns;
  logic [TAG_W-1:0] op_tag;
  logic             op_id;
  logic [63:0]      res_z;
  logic [WD_W-1:0]  wd_cnt;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;
  logic             rsp_fire;
  logic             done;
  logic             wd_hit;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign idle       = (state == IDLE);
  assign accept     = idle & (|grant);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  assign rsp_fire = (rsp0_valid & rsp0_ready)
                  | (rsp1_valid & rsp1_ready);
  assign done     = ~mul_stall;
  assign wd_hit   = mul_stall & (wd_cnt == WD_LAST);

  assign mul_x           = op_x;
  assign mul_y           = op_y;
  assign mul_op_unsigned = op_uns;
  assign rsp0_z          = res_z;
  assign rsp1_z          = res_z;
  assign rsp0_tag        = op_tag;
  assign rsp1_tag        = op_tag;

  // accept -> run -> respond, with watchdog escape to ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_x       <= '0;
      op_y       <= '0;
      op_uns     <= 1'b0;
      op_tag     <= '0;
      op_id      <= 1'b0;
      res_z      <= '0;
      wd_cnt     <= '0;
      mul_run    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
      wd_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_x    <= grant[1] ? req1_x : req0_x;
          op_y    <= grant[1] ? req1_y : req0_y;
          op_uns  <= grant[1] ? req1_unsigned
                              : req0_unsigned;
          op_tag  <= grant[1] ? req1_tag : req0_tag;
          op_id   <= grant[1];
          wd_cnt  <= '0;
          mul_run <= 1'b1;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: unique case (1'b1)
          done: begin
            res_z      <= mul_z;
            mul_run    <= 1'b0;
            rsp0_valid <= ~op_id;
            rsp1_valid <= op_id;
            state      <= RESP;
          end
          wd_hit: begin
            wd_err  <= 1'b1;
            mul_run <= 1'b0;
            state   <= ERR;
          end
          default: wd_cnt <= wd_cnt + WD_W'(1);
        endcase
        RESP: if (rsp_fire) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        ERR: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized self-checking bench
// with a behavioural iterative multiplier model.
module tb_mul_arbiter;
  import mul_arbiter_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid, req0_ready, req0_unsigned;
  logic [31:0] req0_x, req0_y;
  logic [TAG_W-1:0] req0_tag;
  logic req1_valid, req1_ready, req1_unsigned;
  logic [31:0] req1_x, req1_y;
  logic [TAG_W-1:0] req1_tag;
  logic rsp0_valid, rsp0_ready;
  logic [63:0] rsp0_z;
  logic [TAG_W-1:0] rsp0_tag;
  logic rsp1_valid, rsp1_ready;
  logic [63:0] rsp1_z;
  logic [TAG_W-1:0] rsp1_tag;
  logic mul_run, mul_op_unsigned, mul_stall;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_z;
  logic busy, wd_err;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int mcnt = 0;
  bit stuck = 0;
  logic [63:0] prod;

  mul_arbiter #(.TAG_W(TAG_W), .WD_LIMIT(40)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y),
    .req0_unsigned(req0_unsigned), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y),
    .req1_unsigned(req1_unsigned), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_z(rsp0_z), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_z(rsp1_z), .rsp1_tag(rsp1_tag),
    .mul_run(mul_run), .mul_op_unsigned(mul_op_unsigned),
    .mul_x(mul_x), .mul_y(mul_y),
    .mul_stall(mul_stall), .mul_z(mul_z),
    .busy(busy), .wd_err(wd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] x, input logic [31:0] y,
    input logic u);
    longint sx, sy;
    longint unsigned ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (u) return ux * uy;
    return sx * sy;
  endfunction

  // multiplier: stalls MUL_STEPS run cycles, then presents z
  always @(posedge clk) mcnt <= mul_run ? mcnt + 1 : 0;
  always_comb prod = ref_mul(mul_x, mul_y, mul_op_unsigned);
  assign mul_stall = stuck | (mcnt < MUL_STEPS);
  assign mul_z = mul_stall ? 64'hBAD0_BAD0_BAD0_BAD0 : prod;

  task automatic set_req(input int k, input logic v,
    input logic [31:0] x, input logic [31:0] y,
    input logic u, input logic [TAG_W-1:0] t);
    if (k == 0) begin
      req0_valid = v; req0_x = x; req0_y = y;
      req0_unsigned = u; req0_tag = t;
    end else begin
      req1_valid = v; req1_x = x; req1_y = y;
      req1_unsigned = u; req1_tag = t;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stuck = 0;
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, '0);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int k,
    input logic [31:0] x, input logic [31:0] y,
    input logic u, input logic [TAG_W-1:0] t,
    output int acc);
    acc = -1;
    set_req(k, 1'b1, x, y, u, t);
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((k == 0) ? req0_ready : req1_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (k == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k,
    output logic [63:0] z, output logic [TAG_W-1:0] t,
    output int when, output bit other);
    when = -1;
    other = 0;
    z = '0;
    t = '0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if ((k == 0) ? rsp1_valid : rsp0_valid) other = 1;
      if ((k == 0) ? rsp0_valid : rsp1_valid) begin
        z = (k == 0) ? rsp0_z : rsp1_z;
        t = (k == 0) ? rsp0_tag : rsp1_tag;
        when = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, '0);
    set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({mul_run, busy, wd_err, rsp0_valid, rsp1_valid}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
        {mul_run, busy, wd_err, rsp0_valid, rsp1_valid});
    end
    n_tests++;
    if (rsp0_z !== 64'd0 || mul_x !== 32'd0 ||
        mul_y !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: z %0h x %0h y %0h want 0",
        rsp0_z, mul_x, mul_y);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ptr: got %b want 10",
        {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL withdrawn_valid: busy %b want 0", busy);
    end
    req1_valid = 1'b1;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL lone_req1: got %b want 01",
        {req0_ready, req1_ready});
    end
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int acc, when;
    logic [63:0] z;
    logic [TAG_W-1:0] t;
    bit oth;
    do_reset();
    send(0, 32'd7, 32'd6, 1'b1, 4'd3, acc);
    wait_rsp(0, z, t, when, oth);
    n_tests++;
    if (z !== 64'd42) begin
      n_fail++;
      $display("FAIL single_z: got %0h want 2a", z);
    end
    n_tests++;
    if (t !== 4'd3) begin
      n_fail++;
      $display("FAIL single_tag: got %0d want 3", t);
    end
    n_tests++;
    if (acc < 0 || when - acc !== 35) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 35",
        when - acc);
    end
    n_tests++;
    if (oth !== 1'b0) begin
      n_fail++;
      $display("FAIL single_other_rsp: got 1 want 0");
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int acc, when;
    logic [63:0] z;
    logic [TAG_W-1:0] t;
    bit oth;
    do_reset();
    send(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'd5, acc);
    wait_rsp(1, z, t, when, oth);
    n_tests++;
    if (z !== 64'hFFFF_FFFF_FFFF_FFFE || oth) begin
      n_fail++;
      $display("FAIL signed_z: got %0h want fffffffffffffffe",
        z);
    end
    @(negedge clk);
    send(1, 32'hFFFF_FFFF, 32'd2, 1'b1, 4'd6, acc);
    wait_rsp(1, z, t, when, oth);
    n_tests++;
    if (z !== 64'h0000_0001_FFFF_FFFE || t !== 4'd6) begin
      n_fail++;
      $display("FAIL unsigned_z: got %0h/%0d want 1fffffffe/6",
        z, t);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int acc, when, k;
    logic [31:0] x, y;
    logic u;
    logic [TAG_W-1:0] t, tg;
    logic [63:0] z, ez;
    bit oth;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 1);
      x = (i == 0) ? 32'h8000_0000 : $urandom();
      y = (i == 0) ? 32'h8000_0000 : $urandom();
      u = (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      t = TAG_W'($urandom_range(0, 15));
      ez = ref_mul(x, y, u);
      send(k, x, y, u, t, acc);
      wait_rsp(k, z, tg, when, oth);
      n_tests++;
      if (z !== ez || tg !== t || oth || when < 0) begin
        n_fail++;
        $display("FAIL random_op%0d: got %0h/%0d want %0h/%0d",
          i, z, tg, ez, t);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [2];
    logic [31:0] ys [2];
    logic us [2];
    logic [TAG_W-1:0] ts [2];
    logic [63:0] ez [2];
    logic [TAG_W-1:0] et [2];
    int order[$];
    int accs[$];
    int nrsp, pend, g;
    nrsp = 0;
    pend = -1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      xs[k] = $urandom(); ys[k] = $urandom();
      us[k] = 1'($urandom_range(0, 1));
      ts[k] = TAG_W'($urandom_range(0, 15));
      set_req(k, 1'b1, xs[k], ys[k], us[k], ts[k]);
    end
    for (int i = 0; i < 400 && nrsp < 4; i++) begin
      if (order.size() == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else if (pend >= 0) begin
        xs[pend] = $urandom(); ys[pend] = $urandom();
        us[pend] = 1'($urandom_range(0, 1));
        ts[pend] = TAG_W'($urandom_range(0, 15));
        set_req(pend, 1'b1, xs[pend], ys[pend],
          us[pend], ts[pend]);
      end
      pend = -1;
      #1;
      if (rsp0_valid || rsp1_valid) begin
        g = rsp1_valid ? 1 : 0;
        nrsp++;
        n_tests++;
        if ((g ? rsp1_z : rsp0_z) !== ez[g] ||
            (g ? rsp1_tag : rsp0_tag) !== et[g]) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: got %0h want %0h", g,
            g ? rsp1_z : rsp0_z, ez[g]);
        end
      end
      if (req0_ready || req1_ready) begin
        n_tests++;
        if (req0_ready && req1_ready) begin
          n_fail++;
          $display("FAIL b2b_one_grant: got 11 want one-hot");
        end
        g = req1_ready ? 1 : 0;
        order.push_back(g);
        accs.push_back(cyc);
        ez[g] = ref_mul(xs[g], ys[g], us[g]);
        et[g] = ts[g];
        pend = g;
      end
      @(negedge clk);
    end
    n_tests++;
    if (order.size() !== 4 || nrsp !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d/%0d want 4/4",
        order.size(), nrsp);
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      n_tests++;
      if (order[i] !== i % 2) begin
        n_fail++;
        $display("FAIL b2b_order%0d: got %0d want %0d",
          i, order[i], i % 2);
      end
    end
    for (int i = 1; i < accs.size(); i++) begin
      n_tests++;
      if (accs[i] - accs[i-1] !== 36) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d want 36",
          i, accs[i] - accs[i-1]);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_hold();
    int acc, when;
    logic [31:0] x, y;
    logic u;
    logic [TAG_W-1:0] t, tg;
    logic [63:0] z, ez;
    bit oth;
    do_reset();
    rsp0_ready = 1'b0;
    x = $urandom(); y = $urandom();
    u = 1'($urandom_range(0, 1));
    t = TAG_W'($urandom_range(0, 15));
    ez = ref_mul(x, y, u);
    send(0, x, y, u, t, acc);
    wait_rsp(0, z, tg, when, oth);
    n_tests++;
    if (z !== ez || tg !== t) begin
      n_fail++;
      $display("FAIL hold_first: got %0h want %0h", z, ez);
    end
    set_req(1, 1'b1, 32'd9, 32'd11, 1'b1, 4'd12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({rsp0_valid, mul_run, req0_ready, req1_ready,
           rsp1_valid} !== 5'b10000 ||
          rsp0_z !== ez || rsp0_tag !== t) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: ctl %b z %0h want 10000 %0h",
          i, {rsp0_valid, mul_run, req0_ready, req1_ready,
          rsp1_valid}, rsp0_z, ez);
      end
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    send(1, 32'd9, 32'd11, 1'b1, 4'd12, acc);
    wait_rsp(1, z, tg, when, oth);
    n_tests++;
    if (z !== 64'd99 || tg !== 4'd12 || acc < 0) begin
      n_fail++;
      $display("FAIL hold_next: got %0h/%0d want 63/12", z, tg);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int acc, runs;
    bit seen;
    runs = 0;
    seen = 0;
    do_reset();
    stuck = 1;
    send(0, $urandom(), $urandom(), 1'b1, 4'd1, acc);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (wd_err) begin
        seen = 1;
        break;
      end
      if (mul_run) runs++;
      @(negedge clk);
    end
    n_tests++;
    if (!seen || runs !== 40) begin
      n_fail++;
      $display("FAIL wd_runs: got %0d (err %0b) want 40",
        runs, seen);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({mul_run, req0_ready, req1_ready, rsp0_valid,
           rsp1_valid, wd_err, busy} !== 7'b0000011) begin
        n_fail++;
        $display("FAIL wd_absorb%0d: got %b want 0000011", i,
          {mul_run, req0_ready, req1_ready, rsp0_valid,
          rsp1_valid, wd_err, busy});
      end
    end
    do_reset();
    #1;
    n_tests++;
    if ({wd_err, busy, mul_run} !== 3'b000) begin
      n_fail++;
      $display("FAIL wd_cleared: got %b want 000",
        {wd_err, busy, mul_run});
    end
  endtask

  task automatic test_reset_run();
    int acc, when, bad;
    logic [31:0] x, y;
    logic u;
    logic [TAG_W-1:0] t, tg;
    logic [63:0] z, ez;
    bit oth;
    bad = 0;
    do_reset();
    send(1, $urandom(), $urandom(), 1'b0, 4'd7, acc);
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({mul_run, rsp0_valid, rsp1_valid, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL rstrun_async: got %b want 0000",
        {mul_run, rsp0_valid, rsp1_valid, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid || mul_run) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rstrun_quiet: got %0d want 0", bad);
    end
    @(negedge clk);
    x = $urandom(); y = $urandom();
    u = 1'($urandom_range(0, 1));
    t = TAG_W'($urandom_range(0, 15));
    ez = ref_mul(x, y, u);
    send(0, x, y, u, t, acc);
    wait_rsp(0, z, tg, when, oth);
    n_tests++;
    if (z !== ez || tg !== t || when - acc !== 35) begin
      n_fail++;
      $display("FAIL rstrun_fresh: got %0h/%0d want %0h/%0d",
        z, tg, ez, t);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_random();
    test_back_to_back();
    test_hold();
    test_watchdog();
    test_reset_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
